// File: rtl/bufg_pkg.sv
// Shared clocking defaults for the bufg clock buffer and its I-activity monitor.
package bufg_pkg;

    localparam int BUFG_TIMEOUT_DEFAULT = 1024;
    localparam int BUFG_CNT_W_DEFAULT   = 16;
    // Wide enough for the largest legal TIMEOUT (65535).
    localparam int BUFG_TMO_W           = 16;

endpackage

// File: rtl/bufg_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module bufg_sync2 (
    input  logic clk,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    localparam int STAGES = 2;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = d_i;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bufg.sv
// Clock buffer with optional glitch-free enable, plus a CLK-domain monitor
// that counts rising edges of I and flags whether I is still toggling.
module bufg
    import bufg_pkg::*;
#(
    parameter int GATED   = 0,
    parameter int TIMEOUT = BUFG_TIMEOUT_DEFAULT,
    parameter int CNT_W   = BUFG_CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I,
    input  logic             CE,
    output logic             O,
    output logic             ALIVE,
    output logic [CNT_W-1:0] EDGE_CNT
);

    localparam logic [BUFG_TMO_W-1:0] TMO_RELOAD = BUFG_TMO_W'(TIMEOUT);

    // ---------------- clock path ----------------
    generate
        if (GATED != 0) begin : g_gated
            // The latch stores the inverse of the enable so its natural
            // power-up value of 0 means "enabled"; RST never touches it.
            logic en_n_q;

            always_latch begin
                if (!I) begin
                    en_n_q <= ~CE;
                end
            end

            assign O = I & ~en_n_q;
        end else begin : g_buf
            logic unused_ce;
            assign unused_ce = CE;
            assign O = I;
        end
    endgenerate

    // ---------------- monitor ----------------
    logic i_sync;

    bufg_sync2 u_sync (
        .clk   (CLK),
        .rst_i (RST),
        .d_i   (I),
        .q_o   (i_sync)
    );

    logic                  i_prev_q, i_prev_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BUFG_TMO_W-1:0] tmo_q, tmo_d;
    logic                  rise;
    logic                  any_edge;

    always_comb begin
        i_prev_d = i_sync;
        rise     = i_sync & ~i_prev_q;
        any_edge = i_sync ^ i_prev_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        if (rise) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // An edge wins over the final decrement, so ALIVE never blips low.
        if (any_edge) begin
            tmo_d = TMO_RELOAD;
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - BUFG_TMO_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            i_prev_q <= 1'b0;
            cnt_q    <= '0;
            tmo_q    <= '0;
        end else begin
            i_prev_q <= i_prev_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    assign EDGE_CNT = cnt_q;
    assign ALIVE    = (tmo_q != '0);

endmodule

// File: tb/tb_bufg.sv
// Scoreboard bench for bufg: stimulus queues expectations keyed by cycle/slot,
// a monitor compares them against the DUT outputs at the matching sample point.
module tb_bufg;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst;
    logic        i_mon, ce_mon, i_gate, ce_gate;
    logic        o_mon, alive_mon, o_gate, alive_gate;
    logic [15:0] cnt_mon;
    logic [7:0]  cnt_gate;

    bufg #(.GATED(0), .TIMEOUT(16), .CNT_W(16)) u_mon (
        .CLK(CLK), .RST(rst), .I(i_mon), .CE(ce_mon),
        .O(o_mon), .ALIVE(alive_mon), .EDGE_CNT(cnt_mon)
    );

    bufg #(.GATED(1), .TIMEOUT(1024), .CNT_W(8)) u_gate (
        .CLK(CLK), .RST(rst), .I(i_gate), .CE(ce_gate),
        .O(o_gate), .ALIVE(alive_gate), .EDGE_CNT(cnt_gate)
    );

    typedef enum int {S_O_MON, S_ALIVE_MON, S_CNT_MON, S_O_GATE, S_ALIVE_GATE, S_CNT_GATE} sig_e;
    typedef struct {
        int    key;
        sig_e  sig;
        int    exp;
        string name;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Sample slots: key 2*cyc is posedge+1, key 2*cyc+1 is the falling edge.
    task automatic push_key(input int key, input sig_e s, input int e, input string n);
        sb.push_back('{key, s, e, n});
    endtask

    task automatic expect_a(input sig_e s, input int e, input string n);
        push_key(2 * cyc + 1, s, e, n);
    endtask

    task automatic expect_b(input sig_e s, input int e, input string n);
        push_key(2 * (cyc + 1), s, e, n);
    endtask

    function automatic int actual(input sig_e s);
        case (s)
            S_O_MON:      return int'(o_mon);
            S_ALIVE_MON:  return int'(alive_mon);
            S_CNT_MON:    return int'(cnt_mon);
            S_O_GATE:     return int'(o_gate);
            S_ALIVE_GATE: return int'(alive_gate);
            S_CNT_GATE:   return int'(cnt_gate);
            default:      return -1;
        endcase
    endfunction

    task automatic service(input int now_key);
        item_t it;
        int    act;
        while (sb.size() > 0 && sb[0].key <= now_key) begin
            it = sb.pop_front();
            total++;
            if (it.key != now_key) begin
                bad++;
                $display("FAIL %s overdue: due key=%0d now key=%0d", it.name, it.key, now_key);
            end else begin
                act = actual(it.sig);
                if (act != it.exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d actual=%0d required=%0d", it.name, cyc, act, it.exp);
                end else begin
                    $display("check %s cyc=%0d value=%0d ok", it.name, cyc, act);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            service(2 * cyc);
            @(negedge CLK);
            service(2 * cyc + 1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // I at 10 clock periods; optional one-cycle RST at cycle index rst_at.
    task automatic run_mon(input int nper, input int rst_at, output int last_fall);
        last_fall = 0;
        for (int j = 0; j < nper * 10; j++) begin
            tick();
            if (j % 10 == 0) i_mon = 1'b1;
            if (j % 10 == 5) begin
                i_mon = 1'b0;
                last_fall = cyc;
            end
            rst = (j == rst_at);
            expect_a(S_O_MON, int'(i_mon), "o_track");
            if (j == rst_at) begin
                push_key(2 * (cyc + 1) + 1, S_CNT_MON, 0, "midrst_cnt");
                push_key(2 * (cyc + 1) + 1, S_ALIVE_MON, 0, "midrst_alive");
            end
        end
    endtask

    // Gating vectors {I, CE, expected O}, one row per clock cycle.
    localparam int NG = 23;
    logic [2:0] gvec [NG] = '{
        3'b010, 3'b111, 3'b111, 3'b101, 3'b101, 3'b000, 3'b000, 3'b100,
        3'b100, 3'b000, 3'b000, 3'b100, 3'b110, 3'b110, 3'b010, 3'b111,
        3'b111, 3'b010, 3'b000, 3'b110, 3'b110, 3'b010, 3'b111
    };

    initial begin
        int lf;
        int d0;
        rst = 1'b1; i_mon = 1'b0; ce_mon = 1'b0; i_gate = 1'b0; ce_gate = 1'b1;
        repeat (3) tick();
        expect_a(S_CNT_MON, 0, "rst_cnt_mon");
        expect_a(S_ALIVE_MON, 0, "rst_alive_mon");
        expect_a(S_CNT_GATE, 0, "rst_cnt_gate");
        expect_a(S_ALIVE_GATE, 0, "rst_alive_gate");
        expect_a(S_O_MON, 0, "rst_o_mon");
        rst = 1'b0;

        // 100 MHz I on the pure buffer, CE toggling throughout.
        for (int k = 0; k < 8; k++) begin
            tick();
            i_mon = 1'b1;
            ce_mon = 1'(k & 1);
            expect_a(S_O_MON, 1, "buf_hi");
            #5;
            i_mon = 1'b0;
            ce_mon = ~ce_mon;
            expect_b(S_O_MON, 0, "buf_lo");
        end
        tick();
        expect_a(S_CNT_MON, 0, "fast_cnt");
        expect_a(S_ALIVE_MON, 0, "fast_alive");

        // 50 periods of 10 MHz I, then let it stop.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        run_mon(50, -1, lf);
        tick();
        expect_a(S_CNT_MON, 50, "cnt50");
        expect_a(S_ALIVE_MON, 1, "alive50");
        while (cyc < lf + 18) tick();
        expect_a(S_ALIVE_MON, 1, "alive_last");
        tick();
        expect_a(S_ALIVE_MON, 0, "alive_fall");

        // Second edge lands exactly when the counter would expire.
        tick();
        i_mon = 1'b1;
        d0 = cyc;
        while (cyc < d0 + 16) tick();
        i_mon = 1'b0;
        while (cyc < d0 + 19) tick();
        expect_a(S_ALIVE_MON, 1, "edge_at_zero");
        tick();
        expect_a(S_ALIVE_MON, 1, "edge_at_zero_p1");
        expect_a(S_CNT_MON, 51, "cnt51");
        while (cyc < d0 + 34) tick();
        expect_a(S_ALIVE_MON, 1, "refall_last");
        tick();
        expect_a(S_ALIVE_MON, 0, "refall");

        // One-cycle RST while I runs; O keeps tracking, count restarts.
        run_mon(6, 27, lf);
        tick();
        expect_a(S_CNT_MON, 3, "cnt_after_rst");
        expect_a(S_ALIVE_MON, 1, "alive_after_rst");

        // Glitch-free gating vectors.
        for (int r = 0; r < NG; r++) begin
            tick();
            i_gate = gvec[r][2];
            #1;
            ce_gate = gvec[r][1];
            expect_a(S_O_GATE, int'(gvec[r][0]), "gate_a");
            expect_b(S_O_GATE, int'(gvec[r][0]), "gate_b");
        end

        // Counter wrap on the 8-bit instance.
        tick(); i_gate = 1'b0; ce_gate = 1'b1;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        tick();
        for (int e = 0; e < 255; e++) begin
            tick(); i_gate = 1'b1;
            tick();
            tick(); i_gate = 1'b0;
            tick();
        end
        tick();
        tick();
        expect_a(S_CNT_GATE, 255, "cnt_max");
        expect_a(S_ALIVE_GATE, 1, "alive_gate");
        tick(); i_gate = 1'b1;
        d0 = cyc;
        while (cyc < d0 + 4) tick();
        expect_a(S_CNT_GATE, 0, "cnt_wrap");

        tick();
        tick();
        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s never sampled: due key=%0d", sb[0].name, sb[0].key);
            void'(sb.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bufg.md
BUFG -- requirements
Module: bufg

Interface
REQ-001 Parameter GATED, default 0: 0 makes O a pure buffer of I; 1 enables glitch-free gating of O by CE.
REQ-002 Parameter TIMEOUT, default 1024: number of CLK cycles without an I edge before ALIVE deasserts; legal range 4..65535.
REQ-003 Parameter CNT_W, default 16: width of EDGE_CNT.
REQ-004 CLK  input  1  monitor/control clock; all sequential monitor logic is on its rising edge; one clock only.
REQ-005 RST  input  1  reset, synchronous to CLK, active-high.
REQ-006 I  input  1  clock source to be buffered.
REQ-007 CE  input  1  output enable for I; used only when GATED=1.
REQ-008 O  output  1  buffered (optionally gated) copy of I.
REQ-009 ALIVE  output  1  high while I is toggling.
REQ-010 EDGE_CNT  output  CNT_W  count of I rising edges seen in the CLK domain.

Function
REQ-011 With GATED=0, O SHALL equal I combinationally, with zero added delay and no dependence on CLK, RST or CE.
REQ-012 With GATED=1, O SHALL be I AND en, where en is a latch that is transparent while I is low and holds while I is high, so O never produces a runt pulse.
REQ-013 The en latch SHALL power up at 1 and SHALL NOT be affected by RST.
REQ-014 CE changes while I is high SHALL take effect only from the next low phase of I.
REQ-015 I SHALL be synchronized into CLK with a two-flop synchronizer, followed by a third flop for edge detection.
REQ-016 A synchronized rising edge of I SHALL increment EDGE_CNT by 1, wrapping from 2^CNT_W-1 to 0.
REQ-017 EDGE_CNT SHALL update 3 CLK cycles after the I rising edge is first sampled.
REQ-018 A TIMEOUT-cycle down-counter SHALL reload on every synchronized edge of I (rising or falling).
REQ-019 ALIVE SHALL be 1 while that counter is nonzero and SHALL go 0 on the cycle it reaches 0.
REQ-020 An edge arriving on the same cycle the counter reaches 0 SHALL reload the counter and keep ALIVE at 1.
REQ-021 The monitor is correct only if I toggles at most once per two CLK cycles; faster I SHALL undercount without any other malfunction.

Reset
REQ-022 While RST=1 at a CLK edge: the synchronizer flops SHALL clear to 0, EDGE_CNT SHALL clear to 0, the timeout counter SHALL clear to 0, and ALIVE SHALL be 0.
REQ-023 RST SHALL never affect O.
REQ-024 Asserting RST mid-operation SHALL clear the monitor on the next CLK edge; counting SHALL resume on the first edge after RST is released.

Structure
REQ-025 The default TIMEOUT and CNT_W values SHALL live in the shared clocking package; no typedefs are required.
REQ-026 One sub-module, bufg_sync2 (two-flop synchronizer), is natural; the gating latch and the monitor SHALL stay in bufg.

Verification
REQ-027 GATED=0, I = 100 MHz square wave: O SHALL track I with 0 delay; toggling CE SHALL have no effect.
REQ-028 GATED=1, CE driven to 0 in the middle of an I high phase: the current high pulse on O SHALL complete at full width, and O SHALL stay 0 from the next cycle; raising CE in an I high phase SHALL make O resume at the next full rising edge.
REQ-029 CLK = 100 MHz, I = 10 MHz for 50 I periods after RST: EDGE_CNT SHALL read 50 (±1 at the window edge) and ALIVE SHALL be 1.
REQ-030 Stop I with TIMEOUT=16: ALIVE SHALL fall exactly 16 CLK cycles after the last synchronized edge.
REQ-031 Preset EDGE_CNT by driving 65535 edges (CNT_W=16), then apply one more edge: EDGE_CNT SHALL wrap to 0.
REQ-032 Assert RST for one cycle while I is running: EDGE_CNT and ALIVE SHALL be 0 the next cycle, and O SHALL keep toggling without interruption.
